// File: rtl/exec_pkg.sv
// Shared widths, ALU-op encodings, operation codes and EX/MEM control payload
// for the 16-bit CPU execute stage.
package exec_pkg;

  localparam int unsigned EXEC_DATA_W = 16;
  localparam int unsigned EXEC_REG_AW = 4;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_PASSB  = 2'b11;

  localparam logic [3:0] OPC_ADD   = 4'b0000;
  localparam logic [3:0] OPC_SUB   = 4'b0001;
  localparam logic [3:0] OPC_AND   = 4'b0010;
  localparam logic [3:0] OPC_OR    = 4'b0011;
  localparam logic [3:0] OPC_MUL   = 4'b0100;
  localparam logic [3:0] OPC_DIV   = 4'b0101;
  localparam logic [3:0] OPC_SLL   = 4'b1000;
  localparam logic [3:0] OPC_SRL   = 4'b1001;
  localparam logic [3:0] OPC_ROL   = 4'b1010;
  localparam logic [3:0] OPC_ROR   = 4'b1011;
  localparam logic [3:0] OPC_PASSB = 4'b1111;

  typedef struct packed {
    logic mem_to_reg;
    logic mem_write;
    logic mem_read;
    logic r15;
    logic reg_write;
    logic mov_op;
  } exmem_ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 16-bit ALU. MUL/DIV hardware exists only when
// EXEC_MULDIV_EN is defined; otherwise those codes fall through to the default.
module alu_core
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = EXEC_DATA_W
) (
  input  logic [3:0]        operation,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] remainder,
  output logic              ovf
);

  localparam int unsigned SH_W = $clog2(DATA_W);
  localparam int unsigned MSB  = DATA_W - 1;

  logic [SH_W-1:0]   w_sh;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;

  assign w_sh   = op2[SH_W-1:0];
  assign w_sum  = op1 + op2;
  assign w_diff = op1 - op2;

`ifdef EXEC_MULDIV_EN
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]          w_divisor;
  logic [DATA_W-1:0]          w_quot;
  logic [DATA_W-1:0]          w_rem;

  assign w_prod = $signed({{DATA_W{op1[MSB]}}, op1}) * $signed({{DATA_W{op2[MSB]}}, op2});
  // Divisor forced nonzero so the divider never sees 0; that case is overridden below.
  assign w_divisor = (op2 == '0) ? DATA_W'(1) : op2;
  assign w_quot    = $signed(op1) / $signed(w_divisor);
  assign w_rem     = $signed(op1) % $signed(w_divisor);
`endif

  always_comb begin
    result    = op1;
    remainder = '0;
    ovf       = 1'b0;
    case (operation)
      OPC_ADD: begin
        result = w_sum;
        ovf    = (op1[MSB] == op2[MSB]) && (w_sum[MSB] != op1[MSB]);
      end
      OPC_SUB: begin
        result = w_diff;
        ovf    = (op1[MSB] != op2[MSB]) && (w_diff[MSB] != op1[MSB]);
      end
      OPC_AND:   result = op1 & op2;
      OPC_OR:    result = op1 | op2;
`ifdef EXEC_MULDIV_EN
      OPC_MUL: begin
        result    = w_prod[DATA_W-1:0];
        remainder = w_prod[2*DATA_W-1:DATA_W];
        ovf       = w_prod[2*DATA_W-1:DATA_W] != {DATA_W{w_prod[MSB]}};
      end
      OPC_DIV: begin
        if (op2 == '0) begin
          result    = '0;
          remainder = op1;
          ovf       = 1'b1;
        end else if ((op1 == MIN_NEG) && (op2 == '1)) begin
          result = MIN_NEG;
          ovf    = 1'b1;
        end else begin
          result    = w_quot;
          remainder = w_rem;
        end
      end
`endif
      OPC_SLL:   result = op1 << w_sh;
      OPC_SRL:   result = op1 >> w_sh;
      OPC_ROL:   result = (op1 << w_sh) | (op1 >> (DATA_W - 32'(w_sh)));
      OPC_ROR:   result = (op1 >> w_sh) | (op1 << (DATA_W - 32'(w_sh)));
      OPC_PASSB: result = op2;
      default:   result = op1;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU-control decode, alu_core and the EX/MEM pipeline register.
// MUL/DIV support is enabled by defining EXEC_MULDIV_EN.
module exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = EXEC_DATA_W,
  parameter int unsigned REG_AW = EXEC_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        funct,
  input  logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic              flush,
  input  logic              mov_op_in,
  input  logic              mem_to_reg_in,
  input  logic              mem_write_in,
  input  logic              mem_read_in,
  input  logic              r15_in,
  input  logic              reg_write_in,
  input  logic [REG_AW-1:0] reg_rd_in,
  output logic [3:0]        operation,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] alu_remainder_out,
  output logic [DATA_W-1:0] op1_out,
  output logic              mem_to_reg_out,
  output logic              mem_write_out,
  output logic              mem_read_out,
  output logic              r15_out,
  output logic              reg_write_out,
  output logic              mov_op_out,
  output logic              ovf_out,
  output logic [REG_AW-1:0] reg_rd_out
);

  logic [3:0]        w_operation;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] w_remainder;
  logic              w_ovf;
  exmem_ctrl_t       w_ctrl;

  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_alu_remainder;
  logic [DATA_W-1:0] r_op1;
  logic [REG_AW-1:0] r_reg_rd;
  logic              r_ovf;
  exmem_ctrl_t       r_ctrl;

  // ALU control decode
  always_comb begin
    w_operation = OPC_ADD;
    case (alu_op)
      ALUOP_MEM:    w_operation = OPC_ADD;
      ALUOP_BRANCH: w_operation = OPC_SUB;
      ALUOP_RTYPE:  w_operation = funct;
      ALUOP_PASSB:  w_operation = OPC_PASSB;
      default:      w_operation = OPC_ADD;
    endcase
  end

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .operation (w_operation),
    .op1       (op1),
    .op2       (op2),
    .result    (w_result),
    .remainder (w_remainder),
    .ovf       (w_ovf)
  );

  assign w_ctrl = '{mem_to_reg: mem_to_reg_in, mem_write: mem_write_in,
                    mem_read: mem_read_in, r15: r15_in,
                    reg_write: reg_write_in, mov_op: mov_op_in};

  // EX/MEM register; a flush keeps the data but kills every side effect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_result    <= '0;
      r_alu_remainder <= '0;
      r_op1           <= '0;
      r_reg_rd        <= '0;
      r_ovf           <= 1'b0;
      r_ctrl          <= '0;
    end else begin
      r_alu_result    <= w_result;
      r_alu_remainder <= w_remainder;
      r_op1           <= op1;
      r_reg_rd        <= reg_rd_in;
      r_ovf           <= w_ovf & ~flush;
      r_ctrl          <= flush ? '0 : w_ctrl;
    end
  end

  assign operation         = w_operation;
  assign result            = w_result;
  assign ovf               = w_ovf;
  assign alu_result_out    = r_alu_result;
  assign alu_remainder_out = r_alu_remainder;
  assign op1_out           = r_op1;
  assign reg_rd_out        = r_reg_rd;
  assign ovf_out           = r_ovf;
  assign mem_to_reg_out    = r_ctrl.mem_to_reg;
  assign mem_write_out     = r_ctrl.mem_write;
  assign mem_read_out      = r_ctrl.mem_read;
  assign r15_out           = r_ctrl.r15;
  assign reg_write_out     = r_ctrl.reg_write;
  assign mov_op_out        = r_ctrl.mov_op;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed + random stimulus against an
// integer-arithmetic reference model; follows EXEC_MULDIV_EN if defined.
module tb_exec_stage;

`ifdef EXEC_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif
  localparam int N_RAND = 400;
  localparam int N_DIR  = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  funct;
  logic [1:0]  alu_op;
  logic [15:0] op1, op2;
  logic        flush, mov_op_in, mem_to_reg_in, mem_write_in, mem_read_in, r15_in, reg_write_in;
  logic [3:0]  reg_rd_in;
  logic [3:0]  operation;
  logic [15:0] result;
  logic        ovf;
  logic [15:0] alu_result_out, alu_remainder_out, op1_out;
  logic        mem_to_reg_out, mem_write_out, mem_read_out, r15_out, reg_write_out, mov_op_out, ovf_out;
  logic [3:0]  reg_rd_out;

  exec_stage dut (
    .clk(clk), .reset(reset), .funct(funct), .alu_op(alu_op), .op1(op1), .op2(op2),
    .flush(flush), .mov_op_in(mov_op_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_write_in(mem_write_in), .mem_read_in(mem_read_in), .r15_in(r15_in),
    .reg_write_in(reg_write_in), .reg_rd_in(reg_rd_in), .operation(operation),
    .result(result), .ovf(ovf), .alu_result_out(alu_result_out),
    .alu_remainder_out(alu_remainder_out), .op1_out(op1_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out),
    .mem_read_out(mem_read_out), .r15_out(r15_out), .reg_write_out(reg_write_out),
    .mov_op_out(mov_op_out), .ovf_out(ovf_out), .reg_rd_out(reg_rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  opc;
    logic [15:0] res;
    logic [15:0] rem;
    logic        ovf;
    logic [15:0] a;
    logic [3:0]  rd;
    logic        fl;
    logic [5:0]  ct;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_start = 1'b0;
  bit   mon_done  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] decode(input logic [1:0] aop, input logic [3:0] fn);
    case (aop)
      2'd0:    return 4'h0;
      2'd1:    return 4'h1;
      2'd2:    return fn;
      default: return 4'hF;
    endcase
  endfunction

  // Reference ALU computed with 32-bit integer arithmetic
  function automatic void alu_model(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] res, output logic [15:0] rem, output logic v);
    int sa, sb, r;
    logic [15:0] t;
    int n;
    sa = int'($signed(a));
    sb = int'($signed(b));
    n  = int'(b[3:0]);
    res = a; rem = 16'h0; v = 1'b0;
    case (opc)
      4'h0: begin r = sa + sb; res = r[15:0]; v = (r > 32767) || (r < -32768); end
      4'h1: begin r = sa - sb; res = r[15:0]; v = (r > 32767) || (r < -32768); end
      4'h2: res = a & b;
      4'h3: res = a | b;
      4'h4: if (MULDIV) begin
        r = sa * sb; res = r[15:0]; rem = r[31:16]; v = (r > 32767) || (r < -32768);
      end
      4'h5: if (MULDIV) begin
        if (sb == 0) begin res = 16'h0; rem = a; v = 1'b1; end
        else begin
          r = sa / sb; res = r[15:0]; rem = 16'(sa % sb); v = (r > 32767);
        end
      end
      4'h8: res = a << n;
      4'h9: res = a >> n;
      4'hA: begin t = a; for (int i = 0; i < n; i++) t = {t[14:0], t[15]}; res = t; end
      4'hB: begin t = a; for (int i = 0; i < n; i++) t = {t[0], t[15:1]}; res = t; end
      4'hF: res = b;
      default: ;
    endcase
  endfunction

  task automatic drive(input logic [1:0] aop, input logic [3:0] fn, input logic [15:0] a,
                       input logic [15:0] b, input logic fl, input logic [5:0] ct, input logic [3:0] rd);
    exp_t e;
    @(negedge clk);
    alu_op = aop; funct = fn; op1 = a; op2 = b; flush = fl; reg_rd_in = rd;
    {mem_to_reg_in, mem_write_in, mem_read_in, r15_in, reg_write_in, mov_op_in} = ct;
    e.opc = decode(aop, fn);
    alu_model(e.opc, a, b, e.res, e.rem, e.ovf);
    e.a = a; e.rd = rd; e.fl = fl; e.ct = ct;
    q.push_back(e);
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_alu_result"}, 32'(alu_result_out), 32'h0);
    chk({tag, "_remainder"}, 32'(alu_remainder_out), 32'h0);
    chk({tag, "_op1_out"}, 32'(op1_out), 32'h0);
    chk({tag, "_reg_rd"}, 32'(reg_rd_out), 32'h0);
    chk({tag, "_ovf_out"}, 32'(ovf_out), 32'h0);
    chk({tag, "_ctrl"}, 32'({mem_to_reg_out, mem_write_out, mem_read_out, r15_out,
                             reg_write_out, mov_op_out}), 32'h0);
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs just after the edge
  initial begin
    exp_t e;
    wait (mon_start);
    for (int k = 0; k < N_DIR + N_RAND; k++) begin
      @(negedge clk);
      #3;
      if (q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = q[0];
        chk("operation", 32'(operation), 32'(e.opc));
        chk("result", 32'(result), 32'(e.res));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("alu_result_out", 32'(alu_result_out), 32'(e.res));
        chk("alu_remainder_out", 32'(alu_remainder_out), 32'(e.rem));
        chk("op1_out", 32'(op1_out), 32'(e.a));
        chk("reg_rd_out", 32'(reg_rd_out), 32'(e.rd));
        chk("ovf_out", 32'(ovf_out), 32'(e.ovf & ~e.fl));
        chk("ctrl_out", 32'({mem_to_reg_out, mem_write_out, mem_read_out, r15_out,
                             reg_write_out, mov_op_out}), 32'(e.fl ? 6'h0 : e.ct));
      end
    end
    mon_done = 1'b1;
  end

  logic [1:0]  d_aop [N_DIR] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
  logic [3:0]  d_fn  [N_DIR] = '{4'h0, 4'h5, 4'h5, 4'h5, 4'h4, 4'hB, 4'h9,
                                 4'h0, 4'h7, 4'h0, 4'h0, 4'h6, 4'h8, 4'hA};
  logic [15:0] d_a   [N_DIR] = '{16'h7FFF, 16'hFFF9, 16'hFFF9, 16'h8000, 16'h0100, 16'h0001, 16'h8000,
                                 16'h0001, 16'h1234, 16'h8000, 16'h1111, 16'hABCD, 16'hC3A5, 16'hC3A5};
  logic [15:0] d_b   [N_DIR] = '{16'h0001, 16'h0002, 16'h0000, 16'hFFFF, 16'h0100, 16'h0001, 16'h0004,
                                 16'h0002, 16'h0010, 16'h0001, 16'h5A5A, 16'h0003, 16'h0010, 16'h0013};
  logic        d_fl  [N_DIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [15:0] a, b;
    reset = 1'b1;
    alu_op = 2'd0; funct = 4'h0; op1 = 16'h0; op2 = 16'h0; flush = 1'b0; reg_rd_in = 4'h0;
    {mem_to_reg_in, mem_write_in, mem_read_in, r15_in, reg_write_in, mov_op_in} = 6'h0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_regs_zero("reset");
    chk("reset_operation", 32'(operation), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    mon_start = 1'b1;

    for (int i = 0; i < N_DIR; i++)
      drive(d_aop[i], d_fn[i], d_a[i], d_b[i], d_fl[i], 6'h3F, 4'(i));

    for (int i = 0; i < N_RAND; i++) begin
      case ($urandom_range(0, 7))
        0: a = 16'h8000; 1: a = 16'h7FFF; 2: a = 16'hFFFF; 3: a = 16'h0000;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = 16'h0000; 1: b = 16'hFFFF; 2: b = 16'h0001;
        default: b = 16'($urandom);
      endcase
      drive(2'($urandom), 4'($urandom), a, b, $urandom_range(0, 3) == 0, 6'($urandom), 4'($urandom));
    end

    for (int i = 0; i < 50 && !mon_done; i++) @(posedge clk);
    if (!mon_done) chk("monitor_timeout", 32'd0, 32'd1);

    // Asynchronous reset between edges with nonzero registered state
    drive(2'd0, 4'h0, 16'h0001, 16'h0001, 1'b0, 6'h3F, 4'h5);
    void'(q.pop_back());
    @(posedge clk);
    #1;
    chk("pre_reset_result", 32'(alu_result_out), 32'h2);
    chk("pre_reset_reg_write", 32'(reg_write_out), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk_regs_zero("async_reset");
    chk("reset_comb_result", 32'(result), 32'h2);
    @(posedge clk);
    #1;
    chk_regs_zero("reset_held");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_result", 32'(alu_result_out), 32'h2);
    chk("post_reset_reg_rd", 32'(reg_rd_out), 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
